rvv_alu_sequencer: RTL and testbench
====================================

RVV_ALU_SEQUENCER -- requirements
Module: rvv_alu_sequencer

Interface
REQ-001 Parameter VLEN, default 128: vector register length in bits.
REQ-002 Parameter LANE_WIDTH, default 3: log2 of lane width in bits. LW = 2^LANE_WIDTH; legal range 3..6.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 start  input  1  request to execute one vector op; sampled only in IDLE.
REQ-006 opcode  input  6; instr_mask  input  1; op_type  input  3; vsew  input  3  op config, latched on accepted start.
REQ-007 vl  input  17  element count; latched on accepted start.
REQ-008 vd_init  input  VLEN  prior destination contents (tail-undisturbed source); latched on accepted start.
REQ-009 alu_opcode 6, alu_instr_mask 1, alu_op_type 3, alu_vsew 3  outputs  latched config driven to the ALU.
REQ-010 alu_run  output  1  ALU evaluate enable.
REQ-011 alu_byte_i  output  17  element (or mask-chunk) index.
REQ-012 alu_in_reg_offset  output  4  lane chunk index within the current element.
REQ-013 alu_vd  input  64  ALU result; only bits [LW-1:0] are used.
REQ-014 alu_index  input  17  ALU bit index for the current chunk's write.
REQ-015 alu_instr_valid  input  1  ALU opcode legality.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 illegal  output  1  one-cycle pulse, coincident with done, when the op is rejected.
REQ-019 vd_out  output  VLEN  result buffer.

Function
REQ-020 FSM states: IDLE, CHECK, EXEC, FIN.
REQ-021 IDLE: start=1 latches the config, vl and vd_init into vd_out, then enters CHECK.
REQ-022 CHECK (1 cycle): alu_run=0, latched config driven. The op is rejected if any of these hold, and the FSM enters FIN with the illegal flag set:
- alu_instr_valid=0
- vsew>3
- vl > VLEN>>(vsew+3) when instr_mask=0
REQ-023 CHECK, op accepted: vl=0 (non-mask) goes to FIN with no writes; otherwise goes to EXEC with the element counter E=0 and the chunk counter K=0.
REQ-024 Chunks per element C = 2^(vsew+3-LANE_WIDTH) if vsew+3 > LANE_WIDTH, else 1.
REQ-025 Mask ops (instr_mask=1):
- alu_vsew driven as LANE_WIDTH-3 for the whole op
- C=1
- element count = VLEN>>LANE_WIDTH; vl is ignored
REQ-026 EXEC, every cycle:
- alu_run=1, alu_byte_i=E, alu_in_reg_offset=K
- vd_out[alu_index +: LW] <= alu_vd[LW-1:0]
REQ-027 EXEC counter update: K increments each cycle. When K=C-1, K wraps to 0 and E increments. On the last chunk of the last element, the FSM enters FIN.
REQ-028 Chunks of one element are issued on consecutive cycles with no bubbles, so the ALU carry, compare and shift registers chain correctly.
REQ-029 Outside EXEC: alu_run=0, alu_byte_i=0, alu_in_reg_offset=0.
REQ-030 FIN (1 cycle):
- done=1; illegal=1 if the op was rejected
- next state IDLE
REQ-031 vd_out holds its value after FIN until the next accepted start. Bits not written in EXEC equal vd_init.
REQ-032 Rejected ops perform no vd_out writes; vd_out = vd_init.
REQ-033 start is ignored while busy=1; it is not queued.
REQ-034 Latency = 1 (CHECK) + N*C (EXEC) + 1 (FIN) cycles after the accepting edge, where N is the element count.
REQ-035 Config or vl input changes after acceptance have no effect on the op in flight.

Reset
REQ-036 resetn=0 at any edge, including mid-EXEC, forces:
- state IDLE, E=0, K=0
- busy=0, done=0, illegal=0, alu_run=0
- vd_out=0, all latched config=0
REQ-037 An op interrupted by reset produces no done pulse.

Verification
REQ-038 vadd (000000), vsew=0, vl=4, LANE_WIDTH=3: alu_run high 4 cycles with byte_i 0,1,2,3 and offset 0; done 6 cycles after start; vd_out[31:0] = sums, bits [127:32] = vd_init.
REQ-039 vadd, vsew=2, vl=2: 8 EXEC cycles; (byte_i, offset) = (0,0..3) then (1,0..3); vd_out[63:0] = two 32-bit sums with carries propagated; done at cycle 10.
REQ-040 vl=0, legal vand: no alu_run; done at cycle 2, illegal=0; vd_out = vd_init.
REQ-041 Rejected ops, each giving illegal=1 and done at cycle 2 with vd_out = vd_init:
- opcode 111111 with alu_instr_valid=0
- vsew=4
- vsew=3 with vl=3 (VLEN=128 allows at most 2 elements)
REQ-042 vmand (instr_mask=1, 011001): 16 EXEC cycles with byte_i 0..15; a start pulsed mid-EXEC is ignored; done at cycle 18.
REQ-043 resetn=0 at the 3rd EXEC cycle of REQ-039: the next cycle shows busy=0 and vd_out=0, and no done is emitted; a following start runs normally.

Source files
------------

// File: rtl/rvv_alu_sequencer_if.sv
// Request/response and ALU-side signals of the vector ALU sequencer.
// The master drives the op request and the ALU results; the slave is the sequencer.
interface rvv_alu_sequencer_if #(
  parameter int VLEN = 128
);
  logic            start;
  logic [5:0]      opcode;
  logic            instr_mask;
  logic [2:0]      op_type;
  logic [2:0]      vsew;
  logic [16:0]     vl;
  logic [VLEN-1:0] vd_init;

  logic [5:0]      alu_opcode;
  logic            alu_instr_mask;
  logic [2:0]      alu_op_type;
  logic [2:0]      alu_vsew;
  logic            alu_run;
  logic [16:0]     alu_byte_i;
  logic [3:0]      alu_in_reg_offset;
  logic [63:0]     alu_vd;
  logic [16:0]     alu_index;
  logic            alu_instr_valid;

  logic            busy;
  logic            done;
  logic            illegal;
  logic [VLEN-1:0] vd_out;

  modport master (
    output start, opcode, instr_mask, op_type, vsew, vl, vd_init,
    output alu_vd, alu_index, alu_instr_valid,
    input  alu_opcode, alu_instr_mask, alu_op_type, alu_vsew,
    input  alu_run, alu_byte_i, alu_in_reg_offset,
    input  busy, done, illegal, vd_out
  );

  modport slave (
    input  start, opcode, instr_mask, op_type, vsew, vl, vd_init,
    input  alu_vd, alu_index, alu_instr_valid,
    output alu_opcode, alu_instr_mask, alu_op_type, alu_vsew,
    output alu_run, alu_byte_i, alu_in_reg_offset,
    output busy, done, illegal, vd_out
  );
endinterface

// File: rtl/rvv_alu_sequencer.sv
// Sequences one vector ALU op element by element (and lane chunk by chunk),
// merging the ALU's per-chunk results into a tail-undisturbed result buffer.
module rvv_alu_sequencer #(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  rvv_alu_sequencer_if.slave   bus
);

  localparam int LW   = 1 << LANE_WIDTH;
  localparam int IDXW = $clog2(VLEN);

  typedef enum logic [1:0] {IDLE, CHECK, EXEC, FIN} state_t;

  state_t          state_q, state_d;
  logic [5:0]      opcode_q, opcode_d;
  logic            instr_mask_q, instr_mask_d;
  logic [2:0]      op_type_q, op_type_d;
  logic [2:0]      vsew_q, vsew_d;
  logic [16:0]     vl_q, vl_d;
  logic [VLEN-1:0] vd_q, vd_d;
  logic [16:0]     e_q, e_d;
  logic [3:0]      k_q, k_d;
  logic            rej_q, rej_d;

  logic [31:0] width_log2;
  logic [31:0] vl_limit;
  logic [31:0] elem_count;
  logic [31:0] chunk_count;
  logic        last_chunk;
  logic        last_elem;
  logic        reject;
  logic        wr_in_range;
  logic        unused_alu_vd;

  assign unused_alu_vd = ^bus.alu_vd;

  // Mask ops walk the whole register one lane-wide chunk at a time.
  always_comb begin
    width_log2 = 32'(vsew_q) + 32'd3;
    vl_limit   = 32'(VLEN) >> width_log2;
    if (instr_mask_q) begin
      elem_count  = 32'(VLEN >> LANE_WIDTH);
      chunk_count = 32'd1;
    end else begin
      elem_count  = 32'(vl_q);
      chunk_count = (width_log2 > 32'(LANE_WIDTH))
                    ? (32'd1 << (width_log2 - 32'(LANE_WIDTH))) : 32'd1;
    end
  end

  assign last_chunk  = ({28'd0, k_q} == chunk_count - 32'd1);
  assign last_elem   = ({15'd0, e_q} == elem_count - 32'd1);
  assign reject      = !bus.alu_instr_valid || (vsew_q > 3'd3) ||
                       (!instr_mask_q && (32'(vl_q) > vl_limit));
  assign wr_in_range = (32'(bus.alu_index) <= 32'(VLEN - LW));

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    instr_mask_d = instr_mask_q;
    op_type_d    = op_type_q;
    vsew_d       = vsew_q;
    vl_d         = vl_q;
    vd_d         = vd_q;
    e_d          = e_q;
    k_d          = k_q;
    rej_d        = rej_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          opcode_d     = bus.opcode;
          instr_mask_d = bus.instr_mask;
          op_type_d    = bus.op_type;
          vsew_d       = bus.vsew;
          vl_d         = bus.vl;
          vd_d         = bus.vd_init;
          rej_d        = 1'b0;
          state_d      = CHECK;
        end
      end
      CHECK: begin
        e_d = '0;
        k_d = '0;
        if (reject) begin
          rej_d   = 1'b1;
          state_d = FIN;
        end else if (!instr_mask_q && (vl_q == 17'd0)) begin
          state_d = FIN;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (wr_in_range) begin
          vd_d[bus.alu_index[IDXW-1:0] +: LW] = bus.alu_vd[LW-1:0];
        end
        // Chunks of an element issue back to back so ALU carry/shift state chains.
        if (last_chunk) begin
          k_d = '0;
          if (last_elem) begin
            e_d     = '0;
            state_d = FIN;
          end else begin
            e_d = e_q + 17'd1;
          end
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      opcode_q     <= '0;
      instr_mask_q <= 1'b0;
      op_type_q    <= '0;
      vsew_q       <= '0;
      vl_q         <= '0;
      vd_q         <= '0;
      e_q          <= '0;
      k_q          <= '0;
      rej_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      instr_mask_q <= instr_mask_d;
      op_type_q    <= op_type_d;
      vsew_q       <= vsew_d;
      vl_q         <= vl_d;
      vd_q         <= vd_d;
      e_q          <= e_d;
      k_q          <= k_d;
      rej_q        <= rej_d;
    end
  end

  assign bus.alu_opcode        = opcode_q;
  assign bus.alu_instr_mask    = instr_mask_q;
  assign bus.alu_op_type       = op_type_q;
  assign bus.alu_vsew          = instr_mask_q ? 3'(LANE_WIDTH - 3) : vsew_q;
  assign bus.alu_run           = (state_q == EXEC);
  assign bus.alu_byte_i        = (state_q == EXEC) ? e_q : 17'd0;
  assign bus.alu_in_reg_offset = (state_q == EXEC) ? k_q : 4'd0;
  assign bus.busy              = (state_q != IDLE);
  assign bus.done              = (state_q == FIN);
  assign bus.illegal           = (state_q == FIN) && rej_q;
  assign bus.vd_out            = vd_q;

endmodule

// File: tb/tb_rvv_alu_sequencer.sv
// Directed bench for rvv_alu_sequencer with a small byte-lane ALU stand-in
// (vadd with intra-element carry chaining, AND for vand/vmand).
module tb_rvv_alu_sequencer;

  localparam int VLEN = 128;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  rvv_alu_sequencer_if #(.VLEN(VLEN)) bus ();

  rvv_alu_sequencer #(.VLEN(VLEN), .LANE_WIDTH(3)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  logic [VLEN-1:0] vs1, vs2;
  logic            carry_q = 1'b0;
  int              m_idx;
  logic [6:0]      m_sel;
  logic [7:0]      m_a, m_b;
  logic [8:0]      m_sum;

  always_comb begin
    m_idx = int'(bus.alu_byte_i) * (8 << bus.alu_vsew) + int'(bus.alu_in_reg_offset) * 8;
    if (m_idx > VLEN - 8) m_idx = 0;
    m_sel = m_idx[6:0];
    m_a   = vs2[m_sel +: 8];
    m_b   = vs1[m_sel +: 8];
    if (bus.alu_opcode == 6'b000000)
      m_sum = {1'b0, m_a} + {1'b0, m_b} + {8'd0, (bus.alu_in_reg_offset != 4'd0) ? carry_q : 1'b0};
    else
      m_sum = {1'b0, m_a & m_b};
    bus.alu_vd          = {56'd0, m_sum[7:0]};
    bus.alu_index       = 17'(m_idx);
    bus.alu_instr_valid = (bus.alu_opcode != 6'b111111);
  end

  always @(posedge clk) if (bus.alu_run) carry_q <= m_sum[8];

  int total = 0;
  int bad   = 0;

  logic [16:0] seq_b [64];
  logic [3:0]  seq_o [64];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op for a single accepting edge, then scrambles the inputs.
  task automatic launch(input logic [5:0] op, input logic m, input logic [2:0] sew,
                        input logic [16:0] n, input logic [VLEN-1:0] init);
    bus.opcode     = op;
    bus.instr_mask = m;
    bus.op_type    = 3'd1;
    bus.vsew       = sew;
    bus.vl         = n;
    bus.vd_init    = init;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
    bus.opcode     = 6'b111111;
    bus.vsew       = 3'd7;
    bus.vl         = 17'h1ffff;
    bus.vd_init    = '1;
    bus.instr_mask = ~m;
  endtask

  // Observes cycles 1.. after the accepting edge until done (bounded); no checks here.
  task automatic watch(input int poke_cyc, output int runs, output int done_cyc,
                       output logic ill, output int busy_gaps, output int idle_nz,
                       output logic [2:0] run_vsew);
    int cyc;
    runs = 0; done_cyc = 0; ill = 1'b0; busy_gaps = 0; idle_nz = 0; run_vsew = '0;
    cyc = 1;
    while (done_cyc == 0 && cyc <= 60) begin
      if (bus.alu_run) begin
        if (runs < 64) begin
          seq_b[runs] = bus.alu_byte_i;
          seq_o[runs] = bus.alu_in_reg_offset;
        end
        if (runs == 0) run_vsew = bus.alu_vsew;
        runs++;
      end else if (bus.alu_byte_i != 17'd0 || bus.alu_in_reg_offset != 4'd0) begin
        idle_nz++;
      end
      if (!bus.busy) busy_gaps++;
      if (bus.done) begin
        done_cyc = cyc;
        ill      = bus.illegal;
      end else begin
        bus.start = (cyc == poke_cyc);
        tick();
        cyc++;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.start = 1'b0; bus.opcode = '0; bus.instr_mask = 1'b0; bus.op_type = '0;
    bus.vsew = '0; bus.vl = '0; bus.vd_init = '0;
    vs1 = '0; vs2 = '0;
    repeat (3) tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    total++; if (bus.illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal: got %b want 0", bus.illegal); end
    total++; if (bus.alu_run !== 1'b0) begin bad++; $display("FAIL reset_run: got %b want 0", bus.alu_run); end
    total++; if (bus.vd_out !== '0) begin bad++; $display("FAIL reset_vd: got %h want 0", bus.vd_out); end
    total++; if ({bus.alu_opcode, bus.alu_vsew, bus.alu_op_type, bus.alu_instr_mask} !== 13'd0) begin
      bad++; $display("FAIL reset_cfg: got %h want 0", {bus.alu_opcode, bus.alu_vsew, bus.alu_op_type, bus.alu_instr_mask});
    end
    resetn = 1'b1;
    tick();
    $display("reset: busy=%b vd_out=%h", bus.busy, bus.vd_out);
  endtask

  task automatic test_vadd_e8();
    int runs, dc, gaps, nz; logic ill; logic [2:0] rv;
    logic [VLEN-1:0] init, exp_vd;
    init   = {4{32'hDEADBEEF}};
    exp_vd = {96'hDEADBEEF_DEADBEEF_DEADBEEF, 32'h10003300};
    vs2 = {96'd0, 32'hF00122FF};
    vs1 = {96'd0, 32'h20FF1101};
    launch(6'b000000, 1'b0, 3'd0, 17'd4, init);
    watch(0, runs, dc, ill, gaps, nz, rv);
    total++; if (runs !== 4) begin bad++; $display("FAIL e8_runs: got %0d want 4", runs); end
    total++; if (dc !== 6) begin bad++; $display("FAIL e8_done_cycle: got %0d want 6", dc); end
    total++; if (ill !== 1'b0) begin bad++; $display("FAIL e8_illegal: got %b want 0", ill); end
    for (int r = 0; r < runs && r < 4; r++) begin
      total++;
      if (seq_b[r] !== 17'(r) || seq_o[r] !== 4'd0) begin
        bad++; $display("FAIL e8_seq%0d: got (%0d,%0d) want (%0d,0)", r, seq_b[r], seq_o[r], r);
      end
    end
    total++; if (gaps !== 0 || nz !== 0) begin bad++; $display("FAIL e8_busy_idx: got gaps=%0d nz=%0d want 0,0", gaps, nz); end
    total++; if (bus.vd_out !== exp_vd) begin bad++; $display("FAIL e8_vd: got %h want %h", bus.vd_out, exp_vd); end
    tick();
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL e8_idle: got busy=%b done=%b want 0,0", bus.busy, bus.done); end
    tick();
    total++; if (bus.vd_out !== exp_vd) begin bad++; $display("FAIL e8_hold: got %h want %h", bus.vd_out, exp_vd); end
    $display("vadd e8: runs=%0d done_cycle=%0d vd_out=%h", runs, dc, bus.vd_out);
  endtask

  task automatic test_vadd_e32();
    int runs, dc, gaps, nz; logic ill; logic [2:0] rv;
    logic [VLEN-1:0] init, exp_vd;
    init   = {2{64'h0123456789ABCDEF}};
    exp_vd = {64'h0123456789ABCDEF, 64'h22222220_01000000};
    vs2 = {64'd0, 64'h12345678_00FFFFFF};
    vs1 = {64'd0, 64'h0FEDCBA8_00000001};
    launch(6'b000000, 1'b0, 3'd2, 17'd2, init);
    watch(0, runs, dc, ill, gaps, nz, rv);
    total++; if (runs !== 8) begin bad++; $display("FAIL e32_runs: got %0d want 8", runs); end
    total++; if (dc !== 10) begin bad++; $display("FAIL e32_done_cycle: got %0d want 10", dc); end
    for (int r = 0; r < runs && r < 8; r++) begin
      total++;
      if (seq_b[r] !== 17'(r / 4) || seq_o[r] !== 4'(r % 4)) begin
        bad++; $display("FAIL e32_seq%0d: got (%0d,%0d) want (%0d,%0d)", r, seq_b[r], seq_o[r], r / 4, r % 4);
      end
    end
    total++; if (rv !== 3'd2 || bus.alu_opcode !== 6'b000000) begin
      bad++; $display("FAIL e32_cfg: got vsew=%0d op=%b want 2,000000", rv, bus.alu_opcode);
    end
    total++; if (bus.vd_out !== exp_vd) begin bad++; $display("FAIL e32_vd: got %h want %h", bus.vd_out, exp_vd); end
    tick();
    $display("vadd e32: runs=%0d done_cycle=%0d vd_out=%h", runs, dc, bus.vd_out);
  endtask

  task automatic test_vl_zero();
    int runs, dc, gaps, nz; logic ill; logic [2:0] rv;
    logic [VLEN-1:0] init;
    init = {4{32'hCAFEF00D}};
    vs2 = '1; vs1 = '1;
    launch(6'b001001, 1'b0, 3'd0, 17'd0, init);
    watch(0, runs, dc, ill, gaps, nz, rv);
    total++; if (runs !== 0) begin bad++; $display("FAIL vl0_runs: got %0d want 0", runs); end
    total++; if (dc !== 2) begin bad++; $display("FAIL vl0_done_cycle: got %0d want 2", dc); end
    total++; if (ill !== 1'b0) begin bad++; $display("FAIL vl0_illegal: got %b want 0", ill); end
    total++; if (bus.vd_out !== init) begin bad++; $display("FAIL vl0_vd: got %h want %h", bus.vd_out, init); end
    tick();
    $display("vand vl=0: runs=%0d done_cycle=%0d illegal=%b", runs, dc, ill);
  endtask

  task automatic test_illegal();
    int runs, dc, gaps, nz; logic ill; logic [2:0] rv;
    logic [VLEN-1:0] init;
    logic [5:0] op; logic [2:0] sew; logic [16:0] n;
    vs2 = '1; vs1 = '1;
    for (int c = 0; c < 3; c++) begin
      init = {4{32'h5A5A0000 + 32'(c)}};
      case (c)
        0:       begin op = 6'b111111; sew = 3'd0; n = 17'd4; end
        1:       begin op = 6'b000000; sew = 3'd4; n = 17'd1; end
        default: begin op = 6'b000000; sew = 3'd3; n = 17'd3; end
      endcase
      launch(op, 1'b0, sew, n, init);
      watch(0, runs, dc, ill, gaps, nz, rv);
      total++; if (runs !== 0) begin bad++; $display("FAIL ill%0d_runs: got %0d want 0", c, runs); end
      total++; if (dc !== 2) begin bad++; $display("FAIL ill%0d_done_cycle: got %0d want 2", c, dc); end
      total++; if (ill !== 1'b1) begin bad++; $display("FAIL ill%0d_illegal: got %b want 1", c, ill); end
      total++; if (bus.vd_out !== init) begin bad++; $display("FAIL ill%0d_vd: got %h want %h", c, bus.vd_out, init); end
      tick();
      total++; if (bus.illegal !== 1'b0) begin bad++; $display("FAIL ill%0d_pulse: got %b want 0", c, bus.illegal); end
      $display("reject case %0d: runs=%0d done_cycle=%0d illegal=%b", c, runs, dc, ill);
    end
  endtask

  task automatic test_vsew3_boundary();
    int runs, dc, gaps, nz; logic ill; logic [2:0] rv;
    vs2 = 128'h0011223344556677_8899AABBCCDDEEFF;
    vs1 = '0;
    launch(6'b000000, 1'b0, 3'd3, 17'd2, '0);
    watch(0, runs, dc, ill, gaps, nz, rv);
    total++; if (runs !== 16 || ill !== 1'b0) begin bad++; $display("FAIL e64_runs: got %0d ill=%b want 16,0", runs, ill); end
    total++; if (dc !== 18) begin bad++; $display("FAIL e64_done_cycle: got %0d want 18", dc); end
    total++; if (bus.vd_out !== 128'h0011223344556677_8899AABBCCDDEEFF) begin
      bad++; $display("FAIL e64_vd: got %h want 00112233445566778899aabbccddeeff", bus.vd_out);
    end
    tick();
    $display("vadd e64 vl=2: runs=%0d done_cycle=%0d", runs, dc);
  endtask

  task automatic test_mask();
    int runs, dc, gaps, nz; logic ill; logic [2:0] rv;
    logic [VLEN-1:0] exp_vd;
    exp_vd = {8{16'hF000}};
    vs2 = {8{16'hF0F0}};
    vs1 = {8{16'hFF00}};
    launch(6'b011001, 1'b1, 3'd2, 17'd0, {4{32'h12345678}});
    watch(5, runs, dc, ill, gaps, nz, rv);
    total++; if (runs !== 16) begin bad++; $display("FAIL mask_runs: got %0d want 16", runs); end
    total++; if (dc !== 18) begin bad++; $display("FAIL mask_done_cycle: got %0d want 18", dc); end
    for (int r = 0; r < runs && r < 16; r++) begin
      total++;
      if (seq_b[r] !== 17'(r) || seq_o[r] !== 4'd0) begin
        bad++; $display("FAIL mask_seq%0d: got (%0d,%0d) want (%0d,0)", r, seq_b[r], seq_o[r], r);
      end
    end
    total++; if (rv !== 3'd0) begin bad++; $display("FAIL mask_vsew: got %0d want 0", rv); end
    total++; if (bus.vd_out !== exp_vd) begin bad++; $display("FAIL mask_vd: got %h want %h", bus.vd_out, exp_vd); end
    tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mask_no_queue1: got busy=%b want 0", bus.busy); end
    tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mask_no_queue2: got busy=%b want 0", bus.busy); end
    $display("vmand: runs=%0d done_cycle=%0d vd_out=%h", runs, dc, bus.vd_out);
  endtask

  task automatic test_reset_mid();
    int runs, dc, gaps, nz, dones; logic ill; logic [2:0] rv;
    logic [VLEN-1:0] init, exp_vd;
    init   = {2{64'h0123456789ABCDEF}};
    exp_vd = {64'h0123456789ABCDEF, 64'h22222220_01000000};
    vs2 = {64'd0, 64'h12345678_00FFFFFF};
    vs1 = {64'd0, 64'h0FEDCBA8_00000001};
    launch(6'b000000, 1'b0, 3'd2, 17'd2, init);
    tick(); tick(); tick();
    total++; if (bus.alu_run !== 1'b1 || bus.alu_in_reg_offset !== 4'd2) begin
      bad++; $display("FAIL rst_exec3: got run=%b off=%0d want 1,2", bus.alu_run, bus.alu_in_reg_offset);
    end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    total++; if (bus.busy !== 1'b0 || bus.alu_run !== 1'b0) begin
      bad++; $display("FAIL rst_busy: got busy=%b run=%b want 0,0", bus.busy, bus.alu_run);
    end
    total++; if (bus.vd_out !== '0) begin bad++; $display("FAIL rst_vd: got %h want 0", bus.vd_out); end
    total++; if (bus.alu_vsew !== 3'd0 || bus.alu_opcode !== 6'd0) begin
      bad++; $display("FAIL rst_cfg: got vsew=%0d op=%b want 0,000000", bus.alu_vsew, bus.alu_opcode);
    end
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.done) dones++;
      tick();
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL rst_no_done: got %0d want 0", dones); end
    launch(6'b000000, 1'b0, 3'd2, 17'd2, init);
    watch(0, runs, dc, ill, gaps, nz, rv);
    total++; if (dc !== 10 || runs !== 8) begin bad++; $display("FAIL rst_rerun: got done=%0d runs=%0d want 10,8", dc, runs); end
    total++; if (bus.vd_out !== exp_vd) begin bad++; $display("FAIL rst_rerun_vd: got %h want %h", bus.vd_out, exp_vd); end
    tick();
    $display("reset mid-exec: stray dones=%0d rerun done_cycle=%0d", dones, dc);
  endtask

  initial begin
    test_reset();
    test_vadd_e8();
    test_vadd_e32();
    test_vl_zero();
    test_illegal();
    test_vsew3_boundary();
    test_mask();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
